sprite_scaler: RTL and testbench

Parametrised, divider-free sprite fetch engine for the VGA path, running on the pixel clock. It stretches a ROM sprite of any size by an integer scale factor, places it at a runtime position, and optionally mirrors it horizontally. It drives the sprite ROM address, pipelines the ROM colour index, and flags opaque in-sprite pixels for the downstream palette/compositor. Position, scale and mode are latched once per frame, so the sprite never tears.

---
 rtl/sprite_pkg.sv | 47 ++++
 rtl/sprite_axis_stepper.sv | 100 ++++++++++
 rtl/sprite_scaler.sv | 175 +++++++++++++++++
 tb/tb_sprite_scaler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and helpers for the sprite scaler.
//                - shadow_t      : per-frame latched sprite configuration
//                - norm_scale()  : maps a scale of 0 onto 1
//                - pipe_depth()  : input-to-output pipeline depth (2+ROM_LAT)
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Screen coordinate width (columns 0..799, lines 0..524).
    localparam int COORD_W       = 10;
    // Internal scale field width; the scale port may be narrower.
    localparam int SCALE_FIELD_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0]       pos_x;
        logic [COORD_W-1:0]       pos_y;
        logic [SCALE_FIELD_W-1:0] scale;
        logic                     mirror;
        logic                     en;
    } shadow_t;

    // Value held by the shadow registers out of reset: disabled, unit scale.
    localparam shadow_t SHADOW_RESET = '{
        pos_x  : '0,
        pos_y  : '0,
        scale  : 8'd1,
        mirror : 1'b0,
        en     : 1'b0
    };

    // A scale of zero would stall the sub counters; treat it as 1.
    function automatic logic [SCALE_FIELD_W-1:0] norm_scale(
        input logic [SCALE_FIELD_W-1:0] s
    );
        return (s == '0) ? SCALE_FIELD_W'(1) : s;
    endfunction

    // Stage 1 (counters), stage 2 (address), ROM latency, output register.
    function automatic int pipe_depth(input int rom_lat);
        return 2 + rom_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_axis_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_axis_stepper
//  Description : One axis of the sprite walker. A sub counter (0..scale-1)
//                divides the screen coordinate down to texels without a
//                divider; the texel counter saturates at TEXELS-1. A running
//                base (texel*STRIDE) is kept by accumulation so the top level
//                never multiplies. The in-range flag is a registered compare
//                of coord against [pos, pos+span).
//  Ports       : clk_i, rst_ni      - clock, async active-low reset
//                coord_i, pos_i     - screen coordinate and sprite origin
//                span_i             - sprite extent on this axis (TEXELS*scale)
//                scale_i            - normalised scale (>=1)
//                restart_i, step_i  - restart at origin / advance one pixel
//                in_o               - coordinate inside sprite (registered)
//                base_o             - texel*STRIDE (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_axis_stepper
    import sprite_pkg::*;
#(
    parameter int TEXELS = 4,
    parameter int STRIDE = 1,
    parameter int BASE_W = 3,
    parameter int SPAN_W = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [COORD_W-1:0]       coord_i,
    input  logic [COORD_W-1:0]       pos_i,
    input  logic [SPAN_W-1:0]        span_i,
    input  logic [SCALE_FIELD_W-1:0] scale_i,
    input  logic                     restart_i,
    input  logic                     step_i,
    output logic                     in_o,
    output logic [BASE_W-1:0]        base_o
);

    localparam int TEX_W = (TEXELS > 1) ? $clog2(TEXELS) : 1;
    localparam int CMP_W = ((SPAN_W > COORD_W) ? SPAN_W : COORD_W) + 1;

    logic [TEX_W-1:0]         texel_q, texel_d;
    logic [SCALE_FIELD_W-1:0] sub_q, sub_d;
    logic [BASE_W-1:0]        base_q, base_d;
    logic                     in_q, in_d;
    logic [COORD_W-1:0]       offset;
    logic                     sub_wrap;
    logic                     texel_sat;

    always_comb begin
        // offset is only meaningful when coord_i >= pos_i; the compare
        // below is gated by that condition, so no wrap can leak through.
        offset    = coord_i - pos_i;
        in_d      = (coord_i >= pos_i) && (CMP_W'(offset) < CMP_W'(span_i));

        // >= rather than == so a sub count left over from a larger scale
        // in the previous frame still wraps immediately.
        sub_wrap  = (sub_q >= (scale_i - SCALE_FIELD_W'(1)));
        texel_sat = (texel_q == TEX_W'(TEXELS - 1));

        texel_d   = texel_q;
        sub_d     = sub_q;
        base_d    = base_q;

        if (restart_i) begin
            texel_d = '0;
            sub_d   = '0;
            base_d  = '0;
        end else if (step_i) begin
            if (sub_wrap) begin
                sub_d = '0;
                if (!texel_sat) begin
                    texel_d = texel_q + TEX_W'(1);
                    base_d  = base_q + BASE_W'(STRIDE);
                end
            end else begin
                sub_d = sub_q + SCALE_FIELD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            texel_q <= '0;
            sub_q   <= '0;
            base_q  <= '0;
            in_q    <= 1'b0;
        end else begin
            texel_q <= texel_d;
            sub_q   <= sub_d;
            base_q  <= base_d;
            in_q    <= in_d;
        end
    end

    assign in_o   = in_q;
    assign base_o = base_q;

endmodule
`default_nettype wire

// File: rtl/sprite_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_scaler
//  Description : Divider-free sprite fetch engine on the pixel clock.
//                Latches position/scale/mirror/enable at (0,0), walks the
//                sprite with two axis steppers, forms the ROM address from a
//                running row base plus (optionally mirrored) column, delays
//                the hit qualifier alongside the ROM read and registers the
//                colour index and opaque-hit flag.
//                Pipeline: DrawX at edge k -> rom_address at k+1 ->
//                pix_index/pix_hit at k+2+ROM_LAT.
//  Ports       : vga_clk, reset_n           - clock, async active-low reset
//                DrawX, DrawY, blank        - raster position / visible flag
//                pos_x, pos_y, scale,
//                mirror_x, enable           - sprite configuration
//                rom_address, rom_q         - sprite ROM interface
//                pix_index, pix_hit         - pixel output
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_scaler
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 185,
    parameter int SPRITE_H   = 25,
    parameter int IDX_W      = 4,
    parameter int ADDR_W     = $clog2(SPRITE_W * SPRITE_H),
    parameter int SCALE_W    = 3,
    parameter int ROM_LAT    = 1,
    parameter int TRANSP_IDX = 0
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [COORD_W-1:0]  DrawX,
    input  logic [COORD_W-1:0]  DrawY,
    input  logic                blank,
    input  logic [COORD_W-1:0]  pos_x,
    input  logic [COORD_W-1:0]  pos_y,
    input  logic [SCALE_W-1:0]  scale,
    input  logic                mirror_x,
    input  logic                enable,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_W-1:0]    rom_q,
    output logic [IDX_W-1:0]    pix_index,
    output logic                pix_hit
);

    localparam int PIPE_L    = pipe_depth(ROM_LAT);
    localparam int SCALE_MAX = (1 << SCALE_W) - 1;
    localparam int DIM_MAX   = (SPRITE_W > SPRITE_H) ? SPRITE_W : SPRITE_H;
    localparam int SPAN_W    = $clog2(DIM_MAX * SCALE_MAX + 1);

    // ------------------------------------------------------------------
    // Frame latch with same-cycle bypass
    // ------------------------------------------------------------------
    shadow_t shadow_q;
    shadow_t shadow_d;
    shadow_t eff;          // configuration in force for the current pixel
    logic    frame_start;
    logic    line_start;

    always_comb begin
        line_start      = (DrawX == '0);
        frame_start     = line_start && (DrawY == '0);

        shadow_d.pos_x  = pos_x;
        shadow_d.pos_y  = pos_y;
        shadow_d.scale  = norm_scale(SCALE_FIELD_W'(scale));
        shadow_d.mirror = mirror_x;
        shadow_d.en     = enable;

        // On the latch cycle itself the new values must already steer the
        // steppers, otherwise pos_x==0 / pos_y==0 would be missed.
        eff             = frame_start ? shadow_d : shadow_q;
    end

    // ------------------------------------------------------------------
    // Axis steppers (stage 1)
    // ------------------------------------------------------------------
    logic [SPAN_W-1:0] span_x;
    logic [SPAN_W-1:0] span_y;
    logic              x_restart;
    logic              y_restart;
    logic              x_in;
    logic              y_in;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] y_base;

    always_comb begin
        // Constant-by-scale products, evaluated on frame configuration only.
        span_x    = SPAN_W'(SPRITE_W) * SPAN_W'(eff.scale);
        span_y    = SPAN_W'(SPRITE_H) * SPAN_W'(eff.scale);
        x_restart = (DrawX == eff.pos_x);
        y_restart = line_start && (DrawY == eff.pos_y);
    end

    sprite_axis_stepper #(
        .TEXELS (SPRITE_W),
        .STRIDE (1),
        .BASE_W (ADDR_W),
        .SPAN_W (SPAN_W)
    ) u_step_x (
        .clk_i     (vga_clk),
        .rst_ni    (reset_n),
        .coord_i   (DrawX),
        .pos_i     (eff.pos_x),
        .span_i    (span_x),
        .scale_i   (eff.scale),
        .restart_i (x_restart),
        .step_i    (1'b1),
        .in_o      (x_in),
        .base_o    (x_base)
    );

    // The Y base advances by SPRITE_W per texel row: this is the running
    // row-base accumulator that replaces row*SPRITE_W.
    sprite_axis_stepper #(
        .TEXELS (SPRITE_H),
        .STRIDE (SPRITE_W),
        .BASE_W (ADDR_W),
        .SPAN_W (SPAN_W)
    ) u_step_y (
        .clk_i     (vga_clk),
        .rst_ni    (reset_n),
        .coord_i   (DrawY),
        .pos_i     (eff.pos_y),
        .span_i    (span_y),
        .scale_i   (eff.scale),
        .restart_i (y_restart),
        .step_i    (line_start),
        .in_o      (y_in),
        .base_o    (y_base)
    );

    // ------------------------------------------------------------------
    // Address formation (stage 2), delay line and output stage
    // ------------------------------------------------------------------
    logic                vis_q;      // blank & enable, aligned with stage 1
    logic                mirror_q;   // mirror, aligned with stage 1
    logic [PIPE_L-2:0]   hit_pipe_q; // [0] aligns with rom_address
    logic                hit0;
    logic [ADDR_W-1:0]   col;
    logic [ADDR_W-1:0]   addr;
    logic                hit_out;

    always_comb begin
        hit0    = x_in & y_in & vis_q;
        col     = mirror_q ? (ADDR_W'(SPRITE_W - 1) - x_base) : x_base;
        addr    = y_base + col;
        hit_out = hit_pipe_q[PIPE_L-2] && (rom_q != IDX_W'(TRANSP_IDX));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q    <= SHADOW_RESET;
            vis_q       <= 1'b0;
            mirror_q    <= 1'b0;
            rom_address <= '0;
            hit_pipe_q  <= '0;
            pix_index   <= '0;
            pix_hit     <= 1'b0;
        end else begin
            if (frame_start) begin
                shadow_q <= shadow_d;
            end
            vis_q       <= blank & eff.en;
            mirror_q    <= eff.mirror;
            rom_address <= hit0 ? addr : '0;
            hit_pipe_q  <= {hit_pipe_q[PIPE_L-3:0], hit0};
            pix_hit     <= hit_out;
            pix_index   <= hit_out ? rom_q : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_scaler
//  Description : Scoreboard bench for sprite_scaler (4x2 sprite, ROM_LAT=1,
//                ROM content = address). Each driven pixel pushes the
//                expected rom_address and pixel output, tagged with the
//                clock edge after which they must appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_scaler;

    localparam int SW      = 4;
    localparam int SH      = 2;
    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 3;
    localparam int SCALE_W = 3;
    localparam int ROM_LAT = 1;
    localparam int TRANSP  = 0;
    localparam int PIPE_L  = 2 + ROM_LAT;

    logic               vga_clk;
    logic               reset_n;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               blank;
    logic [9:0]         pos_x;
    logic [9:0]         pos_y;
    logic [SCALE_W-1:0] scale;
    logic               mirror_x;
    logic               enable;
    logic [ADDR_W-1:0]  rom_address;
    logic [IDX_W-1:0]   rom_q;
    logic [IDX_W-1:0]   pix_index;
    logic               pix_hit;

    sprite_scaler #(
        .SPRITE_W   (SW),
        .SPRITE_H   (SH),
        .IDX_W      (IDX_W),
        .ADDR_W     (ADDR_W),
        .SCALE_W    (SCALE_W),
        .ROM_LAT    (ROM_LAT),
        .TRANSP_IDX (TRANSP)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .scale       (scale),
        .mirror_x    (mirror_x),
        .enable      (enable),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pix_index   (pix_index),
        .pix_hit     (pix_hit)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM, one cycle latency, content = address.
    always @(posedge vga_clk) rom_q <= {1'b0, rom_address};

    typedef struct {
        int due;
        int addr;
        bit hit;
        int idx;
    } exp_t;

    exp_t addr_q[$];
    exp_t pix_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int edge_n   = 0;
    int rst_hold = 0;

    // Reference model of the shadow registers.
    int m_px  = 0;
    int m_py  = 0;
    int m_s   = 1;
    bit m_mir = 1'b0;
    bit m_en  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_px  = 0;
        m_py  = 0;
        m_s   = 1;
        m_mir = 1'b0;
        m_en  = 1'b0;
    endtask

    task automatic set_cfg(input int px, input int py, input int s,
                           input bit mir, input bit en);
        pos_x    = 10'(px);
        pos_y    = 10'(py);
        scale    = SCALE_W'(s);
        mirror_x = mir;
        enable   = en;
    endtask

    task automatic drive_pixel(input int x, input int y);
        exp_t e;
        bit   bl, in_x, in_y, h0, hit;
        int   col, row, addr;
        @(negedge vga_clk);
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset_n = 1'b1;
        end
        bl    = (x < 640) && (y < 480);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        if (reset_n && x == 0 && y == 0) begin
            m_px  = int'(pos_x);
            m_py  = int'(pos_y);
            m_s   = (scale == '0) ? 1 : int'(scale);
            m_mir = mirror_x;
            m_en  = enable;
        end
        in_x = (x >= m_px) && (x < m_px + SW * m_s);
        in_y = (y >= m_py) && (y < m_py + SH * m_s);
        h0   = in_x && in_y && bl && m_en && (reset_n == 1'b1);
        addr = 0;
        if (h0) begin
            col = (x - m_px) / m_s;
            row = (y - m_py) / m_s;
            if (m_mir) col = SW - 1 - col;
            addr = row * SW + col;
        end
        hit    = h0 && (addr != TRANSP);
        e.due  = edge_n + 2;
        e.addr = addr;
        e.hit  = 1'b0;
        e.idx  = 0;
        addr_q.push_back(e);
        e.due  = edge_n + 1 + PIPE_L;
        e.hit  = hit;
        e.idx  = hit ? addr : 0;
        pix_q.push_back(e);
    endtask

    // Asynchronous reset between clock edges; in-flight pixels are lost.
    task automatic do_reset();
        @(posedge vga_clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        foreach (addr_q[i]) addr_q[i].addr = 0;
        foreach (pix_q[i]) begin
            pix_q[i].hit = 1'b0;
            pix_q[i].idx = 0;
        end
        #1;
        check_eq("async_rst_rom_address", 32'(rom_address), 0);
        check_eq("async_rst_pix_hit", 32'(pix_hit), 0);
        check_eq("async_rst_pix_index", 32'(pix_index), 0);
        rst_hold = 3;
    endtask

    // Compressed raster: each line visits columns 0..23 and 630..645.
    task automatic run_frame(input int n_lines, input int rst_line, input int rst_x,
                             input int chg_line, input int chg_px);
        for (int y = 0; y < n_lines; y++) begin
            if (y == chg_line) pos_x = 10'(chg_px);
            for (int x = 0; x < 24; x++) begin
                drive_pixel(x, y);
                if (y == rst_line && x == rst_x) do_reset();
            end
            for (int x = 630; x < 646; x++) drive_pixel(x, y);
        end
    endtask

    // Monitor: compare everything due after the edge just taken.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            edge_n++;
            while (addr_q.size() > 0 && addr_q[0].due == edge_n) begin
                e = addr_q.pop_front();
                check_eq("rom_address", 32'(rom_address), 32'(e.addr));
            end
            while (pix_q.size() > 0 && pix_q[0].due == edge_n) begin
                e = pix_q.pop_front();
                check_eq("pix_hit", 32'(pix_hit), 32'(e.hit));
                check_eq("pix_index", 32'(pix_index), 32'(e.idx));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin : stimulus
        reset_n = 1'b0;
        DrawX   = 10'd100;
        DrawY   = 10'd100;
        blank   = 1'b0;
        set_cfg(0, 0, 1, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge vga_clk);
        @(posedge vga_clk);
        #2;
        check_eq("reset_rom_address", 32'(rom_address), 0);
        check_eq("reset_pix_hit", 32'(pix_hit), 0);
        check_eq("reset_pix_index", 32'(pix_index), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Unit scale at (10,5).
        set_cfg(10, 5, 1, 1'b0, 1'b1);
        run_frame(9, -1, 0, -1, 0);
        // Scale 3: rows span lines 5..7 and 8..10, line 11 empty.
        set_cfg(10, 5, 3, 1'b0, 1'b1);
        run_frame(13, -1, 0, -1, 0);
        // Horizontal mirror.
        set_cfg(10, 5, 1, 1'b1, 1'b1);
        run_frame(8, -1, 0, -1, 0);
        // Scale 0 behaves as 1; right-edge clipping at column 640.
        set_cfg(638, 5, 0, 1'b0, 1'b1);
        run_frame(8, -1, 0, -1, 0);
        // pos_x change mid-frame is ignored until the next latch.
        set_cfg(10, 5, 1, 1'b0, 1'b1);
        run_frame(8, -1, 0, 2, 15);
        run_frame(8, -1, 0, -1, 0);
        // Origin at (0,0): latch bypass and Y-step/X-restart coincidence.
        set_cfg(0, 0, 2, 1'b1, 1'b1);
        run_frame(6, -1, 0, -1, 0);
        // Reset in the middle of the sprite, then a clean frame.
        set_cfg(10, 5, 1, 1'b0, 1'b1);
        run_frame(9, 5, 12, -1, 0);
        run_frame(8, -1, 0, -1, 0);
        // Disabled sprite.
        set_cfg(10, 5, 1, 1'b0, 1'b0);
        run_frame(8, -1, 0, -1, 0);

        repeat (PIPE_L + 3) @(negedge vga_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
